imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the core's immediate generator. Takes an immediate value, a format select and a base instruction word, then inserts the immediate bits into the instruction's immediate fields to produce a legal 32-bit RV64 encoding.
- Checks that the immediate is representable and aligned for the chosen format.
- Streams through a 2-stage valid/ready pipeline with backpressure.
- Used by the debug instruction injector and the self-test program builder to produce branch, jump and load/store words at run time.

Parameters:
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input request valid.
- in_ready  out  1  block can accept the input this cycle.
- in_fmt  in  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J; 101-111 illegal.
- in_imm  in  64  immediate value, two's complement.
- in_base  in  32  instruction word; supplies all non-immediate bits.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_instr  out  32  encoded instruction.
- out_err  out  1  request rejected; out_instr = in_base unchanged.
- out_err_code  out  2  00 ok, 01 out of range, 10 misaligned, 11 illegal format.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - No combinational path from in_valid to out_valid.
- Pipeline stages:
  - S1 registers the inputs together with the range and alignment check results.
  - S2 is the output register and drives out_*.
- Latency and throughput: 2 cycles from input transfer to out_valid with no stall; throughput 1 per cycle.
- Stage advance:
  - S2 loads from S1 when S2 is empty or S2 is transferring this cycle.
  - S1 loads when S1 is empty or S1 is advancing.
  - in_ready = !s1_valid || s1_adv (combinational; 0 while rst is high).
- Stall behaviour:
  - While out_valid && !out_ready, S2 holds its value and out_* must be stable.
  - At most 2 requests are in flight; order is preserved and no request is dropped or duplicated.
- Representability checks:
  - I/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094], imm[0] must be 0.
  - U: imm[43:0] must be 0; the field is imm[63:44]. This matches the core's U-type extension convention.
  - J: imm in [-1048576, 1048574], imm[0] must be 0.
  - "In range" means imm[63:N-1] are all equal, where N is the field width (12, 13 or 21).
- Error priority: illegal format (11) > misaligned (10) > out of range (01).
- Field placement (immediate bits overwrite base bits; all other base bits pass through):
  - I: [31:20] = imm[11:0].
  - S: [31:25] = imm[11:5]; [11:7] = imm[4:0].
  - B: [31] = imm[12]; [30:25] = imm[10:5]; [11:8] = imm[4:1]; [7] = imm[11].
  - U: [31:12] = imm[63:44].
  - J: [31] = imm[20]; [30:21] = imm[10:1]; [20] = imm[11]; [19:12] = imm[19:12].
- On error: out_instr = in_base, out_err = 1, out_err_code as above. An error result occupies the pipeline like a normal result.
- Reset:
  - out_valid = 0, out_instr = 0, out_err = 0, out_err_code = 00, s1_valid = 0, in_ready = 0.
  - Reset asserted mid-operation discards all in-flight requests; no output is produced for them.
  - in_ready returns to 1 in the first cycle after rst deasserts.
- Simultaneous events: input and output transfers in the same cycle with both stages full are legal; occupancy stays 2.

Optional Feature:
- IMM_ENCODER_STATS_EN defined:
  - Adds outputs stat_ok (CNT_W) and stat_err (CNT_W).
  - Each counter increments on an output transfer with out_err = 0 / 1 respectively.
  - Counters saturate at all-ones and clear on rst.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- I-type: fmt=000, imm=0xFFFFFFFFFFFFFFFF, base=0x00000013 -> out_instr=0xFFF00013, err=0, out_valid exactly 2 cycles after the transfer.
- S-type: fmt=001, imm=0x7E4, base=0x00002023 -> 0x7E002223. B-type: fmt=010, imm=-4, base=0x00000063 -> 0xFE000EE3.
- Errors:
  - fmt=000, imm=2048 -> err=1, code=01, out_instr=base.
  - fmt=100, imm=0x3 -> code=10.
  - fmt=111 with an out-of-range imm -> code=11.
- Backpressure:
  - Setup: out_ready=0 for 4 cycles, 3 requests offered back-to-back.
  - Required: in_ready drops after 2 accepts, out_* stable during the stall.
  - On release: results emerge in order; third accepted on the first release cycle.
- Reset mid-stream: 2 requests in flight, pulse rst one cycle -> out_valid=0 next cycle, no stale output; in_ready=1 after release.
- Stats (IMM_ENCODER_STATS_EN, CNT_W=4): 20 ok transfers -> stat_ok saturates at 15; 1 error -> stat_err=1.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: inserts an immediate into the immediate fields of a base RV64
// instruction word (I/S/B/U/J formats). It checks that the immediate is
// representable and aligned, and streams results through a two-stage
// valid/ready pipeline.
// Optional feature macro: IMM_ENCODER_STATS_EN adds saturating ok/error
// transfer counters (stat_ok, stat_err).
//
// Handshake: a beat transfers on any edge where valid && ready. A producer
// holds valid and its payload until the transfer. in_ready never depends on
// in_valid, so there is no combinational path from in_valid to out_valid.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [63:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [1:0]       out_err_code
`ifdef IMM_ENCODER_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_ok,
  output logic [CNT_W-1:0] stat_err
`endif
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_FMT   = 2'b11;

  // Stage 1 holds the finished word and its check result. Encoding is done
  // on the way into S1, so S2 is a plain output register.
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_instr_q, s1_instr_d;
  logic [1:0]  s1_code_q,  s1_code_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [1:0]  out_code_q,  out_code_d;

  logic in_xfer, out_xfer, s1_adv;
  logic range_ok, align_ok, fmt_ok;
  logic [31:0] enc_instr;

  assign out_xfer = out_valid_q && out_ready;
  assign s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !rst && (!s1_valid_q || s1_adv);
  assign in_xfer  = in_valid && in_ready;

  // Range/alignment checks and field placement for the incoming request.
  always_comb begin
    range_ok  = 1'b1;
    align_ok  = 1'b1;
    fmt_ok    = 1'b1;
    enc_instr = in_base;
    case (in_fmt)
      FMT_I: begin
        range_ok         = (&in_imm[63:11]) || !(|in_imm[63:11]);
        enc_instr[31:20] = in_imm[11:0];
      end
      FMT_S: begin
        range_ok         = (&in_imm[63:11]) || !(|in_imm[63:11]);
        enc_instr[31:25] = in_imm[11:5];
        enc_instr[11:7]  = in_imm[4:0];
      end
      FMT_B: begin
        range_ok         = (&in_imm[63:12]) || !(|in_imm[63:12]);
        align_ok         = !in_imm[0];
        enc_instr[31]    = in_imm[12];
        enc_instr[30:25] = in_imm[10:5];
        enc_instr[11:8]  = in_imm[4:1];
        enc_instr[7]     = in_imm[11];
      end
      FMT_U: begin
        // Upper 20 bits are the field; anything below bit 44 is unencodable.
        align_ok         = !(|in_imm[43:0]);
        enc_instr[31:12] = in_imm[63:44];
      end
      FMT_J: begin
        range_ok         = (&in_imm[63:20]) || !(|in_imm[63:20]);
        align_ok         = !in_imm[0];
        enc_instr[31]    = in_imm[20];
        enc_instr[30:21] = in_imm[10:1];
        enc_instr[20]    = in_imm[11];
        enc_instr[19:12] = in_imm[19:12];
      end
      default: fmt_ok = 1'b0;
    endcase
  end

  // S1 next state: load on input transfer, empty when advancing without refill.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_instr_d = s1_instr_q;
    s1_code_d  = s1_code_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      if (!fmt_ok) begin
        s1_code_d  = ERR_FMT;
        s1_instr_d = in_base;
      end else if (!align_ok) begin
        s1_code_d  = ERR_ALIGN;
        s1_instr_d = in_base;
      end else if (!range_ok) begin
        s1_code_d  = ERR_RANGE;
        s1_instr_d = in_base;
      end else begin
        s1_code_d  = ERR_OK;
        s1_instr_d = enc_instr;
      end
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 next state: take S1 when it advances, empty after an unrefilled transfer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_code_d  = out_code_q;
    if (s1_adv) begin
      out_valid_d = 1'b1;
      out_instr_d = s1_instr_q;
      out_code_d  = s1_code_q;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers; reset drops every in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_instr_q  <= '0;
      s1_code_q   <= ERR_OK;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_code_q  <= ERR_OK;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_instr_q  <= s1_instr_d;
      s1_code_q   <= s1_code_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_code_q  <= out_code_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_err_code = out_code_q;
  assign out_err      = (out_code_q != ERR_OK);

`ifdef IMM_ENCODER_STATS_EN
  logic [CNT_W-1:0] stat_ok_q, stat_ok_d;
  logic [CNT_W-1:0] stat_err_q, stat_err_d;

  // Saturating counters of ok / error output transfers.
  always_comb begin
    stat_ok_d  = stat_ok_q;
    stat_err_d = stat_err_q;
    if (out_xfer && !out_err && !(&stat_ok_q))
      stat_ok_d = stat_ok_q + 1'b1;
    if (out_xfer && out_err && !(&stat_err_q))
      stat_err_d = stat_err_q + 1'b1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ok_q  <= '0;
      stat_err_q <= '0;
    end else begin
      stat_ok_q  <= stat_ok_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_ok  = stat_ok_q;
  assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed testbench for imm_encoder: a vector table for encode/error cases,
// plus hand-written sequences for backpressure, mid-stream reset and
// (with IMM_ENCODER_STATS_EN) the saturating statistics counters.
module tb_imm_encoder;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [63:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [1:0]  out_err_code;
`ifdef IMM_ENCODER_STATS_EN
  logic [CNT_W-1:0] stat_ok;
  logic [CNT_W-1:0] stat_err;
`endif

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_fmt       (in_fmt),
    .in_imm       (in_imm),
    .in_base      (in_base),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_err      (out_err),
    .out_err_code (out_err_code)
`ifdef IMM_ENCODER_STATS_EN
    ,
    .stat_ok      (stat_ok),
    .stat_err     (stat_err)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [31:0] base;
    logic [31:0] exp_instr;
    logic        exp_err;
    logic [1:0]  exp_code;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // Scoreboard compare
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: one request through an idle pipeline, checking 2-cycle latency.
  task automatic run_vec(input vec_t v, input int idx);
    in_fmt    = v.fmt;
    in_imm    = v.imm;
    in_base   = v.base;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_in_ready", idx), {63'd0, in_ready}, 64'd1);
    step();                         // transfer edge
    in_valid = 1'b0;
    chk($sformatf("v%0d_early_valid", idx), {63'd0, out_valid}, 64'd0);
    step();                         // second cycle after transfer
    chk($sformatf("v%0d_out_valid", idx), {63'd0, out_valid}, 64'd1);
    chk($sformatf("v%0d_instr", idx), {32'd0, out_instr}, {32'd0, v.exp_instr});
    chk($sformatf("v%0d_err", idx), {63'd0, out_err}, {63'd0, v.exp_err});
    chk($sformatf("v%0d_code", idx), {62'd0, out_err_code}, {62'd0, v.exp_code});
    step();                         // output transferred
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  vec_t vecs[18];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_fmt = 3'd0; in_imm = 64'd0;
    in_base = 32'd0; out_ready = 1'b1;

    //                 fmt    imm                        base          exp_instr     err   code
    vecs[0]  = '{3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0, 2'b00};
    vecs[1]  = '{3'd1, 64'h0000_0000_0000_07E4, 32'h0000_2023, 32'h7E00_2223, 1'b0, 2'b00};
    vecs[2]  = '{3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0, 2'b00};
    vecs[3]  = '{3'd0, 64'd2048,                32'h0000_0013, 32'h0000_0013, 1'b1, 2'b01};
    vecs[4]  = '{3'd4, 64'h3,                   32'h0000_006F, 32'h0000_006F, 1'b1, 2'b10};
    vecs[5]  = '{3'd7, 64'h0000_0001_0000_0000, 32'h0000_0013, 32'h0000_0013, 1'b1, 2'b11};
    vecs[6]  = '{3'd3, 64'h1234_5000_0000_0000, 32'h0000_0037, 32'h1234_5037, 1'b0, 2'b00};
    vecs[7]  = '{3'd4, 64'd2048,                32'h0000_006F, 32'h0010_006F, 1'b0, 2'b00};
    vecs[8]  = '{3'd4, 64'hFFFF_FFFF_FFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 1'b0, 2'b00};
    vecs[9]  = '{3'd2, 64'd4096,                32'h0000_0063, 32'h0000_0063, 1'b1, 2'b01};
    vecs[10] = '{3'd2, 64'd4097,                32'h0000_0063, 32'h0000_0063, 1'b1, 2'b10};
    vecs[11] = '{3'd0, 64'hFFFF_FFFF_FFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0, 2'b00};
    vecs[12] = '{3'd1, 64'h7FF,                 32'h0000_2023, 32'h7E00_2FA3, 1'b0, 2'b00};
    vecs[13] = '{3'd3, 64'h1,                   32'h0000_0037, 32'h0000_0037, 1'b1, 2'b10};
    vecs[14] = '{3'd4, 64'h000F_FFFE,           32'h0000_006F, 32'h7FFF_F06F, 1'b0, 2'b00};
    vecs[15] = '{3'd4, 64'h0010_0000,           32'h0000_006F, 32'h0000_006F, 1'b1, 2'b01};
    vecs[16] = '{3'd0, 64'h0,                   32'hABCD_E013, 32'h000D_E013, 1'b0, 2'b00};
    vecs[17] = '{3'd1, 64'hFFFF_FFFF_FFFF_F7FF, 32'h0000_2023, 32'h0000_2023, 1'b1, 2'b01};

    // Reset state
    step();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
    chk("rst_out_err", {63'd0, out_err}, 64'd0);
    chk("rst_code", {62'd0, out_err_code}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", {63'd0, in_ready}, 64'd1);

    // Table-driven vectors
    for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

    // Backpressure: out_ready low for 4 cycles, 3 requests offered
    begin
      int sent = 0;
      int got = 0;
      int third_acc = -1;
      logic [31:0] held = 32'd0;
      exp_q.delete();
      for (int c = 0; c < 10; c++) begin
        out_ready = (c >= 4);
        if (sent < 3) begin
          in_valid = 1'b1;
          in_fmt   = 3'd0;
          in_imm   = 64'(sent + 1);
          in_base  = 32'h0000_0013;
        end else begin
          in_valid = 1'b0;
        end
        #1;
        if (c == 2 || c == 3)
          chk($sformatf("bp_in_ready_c%0d", c), {63'd0, in_ready}, 64'd0);
        if (c == 2) held = out_instr;
        if (c == 3) begin
          chk("bp_stall_valid", {63'd0, out_valid}, 64'd1);
          chk("bp_stall_instr", {32'd0, out_instr}, {32'd0, held});
          chk("bp_stall_err", {63'd0, out_err}, 64'd0);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("bp_extra_output", 64'd1, 64'd0);
          else chk("bp_order", {32'd0, out_instr}, {32'd0, exp_q.pop_front()});
          got++;
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(32'((sent + 1) << 20) | 32'h13);
          if (sent == 2) third_acc = c;
          sent++;
        end
        step();
      end
      chk("bp_third_accept_cycle", 64'(third_acc), 64'd4);
      chk("bp_outputs", 64'(got), 64'd3);
      chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    end

    // Reset mid-stream with 2 requests in flight
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_fmt = 3'd0; in_imm = 64'(c + 5); in_base = 32'h13;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mid_rst_release_ready", {63'd0, in_ready}, 64'd1);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("mid_rst_no_stale_c%0d", c), {63'd0, out_valid}, 64'd0);
      step();
    end

`ifdef IMM_ENCODER_STATS_EN
    // Statistics counters saturate; errors counted separately
    do_reset();
    chk("stat_ok_reset", 64'(stat_ok), 64'd0);
    for (int i = 0; i < 20; i++) run_vec(vecs[0], 100 + i);
    chk("stat_ok_sat", 64'(stat_ok), 64'd15);
    chk("stat_err_none", 64'(stat_err), 64'd0);
    run_vec(vecs[3], 200);
    chk("stat_err_one", 64'(stat_err), 64'd1);
    chk("stat_ok_hold", 64'(stat_ok), 64'd15);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
